// File: rtl/swi_step_ctrl.sv
// Purpose: conditions the raw slide switches (sync, debounce, rise detect) and generates cpu_en.
// Latency: a stable SWI change reaches swi_clean after DB_CYCLES+2 edges; cpu_en follows swi_rise by 1 cycle.
// Backpressure: none; inputs are free-running levels and outputs are level/pulse signals.
`timescale 1ns/1ps
module swi_step_ctrl #(
  parameter int NBITS     = 8,
  parameter int DB_CYCLES = 16,
  parameter int RUN_DIV   = 4,
  parameter int STEP_BIT  = 7,
  parameter int MODE_BIT  = 6
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] swi_clean,
  output logic [NBITS-1:0] swi_rise,
  output logic             cpu_en,
  output logic             run_mode
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int DW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(RUN_DIV - 1);

  typedef enum logic {
    ST_STEP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [NBITS-1:0] s1;
  logic [NBITS-1:0] s2;
  logic [CW-1:0]    cnt [NBITS];
  logic [NBITS-1:0] accept;
  logic [NBITS-1:0] clean_nxt;
  state_t           state;
  state_t           state_nxt;
  logic [DW-1:0]    div;
  logic             step_en;

  // Two-flop synchroniser; everything downstream sees only s2.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SWI;
      s2 <= s1;
    end
  end

  // A bit is accepted when it has differed from the clean value for DB_CYCLES cycles in a row.
  always_comb begin
    accept = '0;
    for (int i = 0; i < NBITS; i++) begin
      accept[i] = (s2[i] != swi_clean[i]) && (cnt[i] == CNT_LAST);
    end
    clean_nxt = swi_clean ^ accept;
  end

  // Per-bit stability counters; any agreement with the clean value restarts the count.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NBITS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        if ((s2[i] == swi_clean[i]) || accept[i]) cnt[i] <= '0;
        else                                      cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Clean levels and their 0->1 pulses are registered together so they line up.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      swi_clean <= '0;
      swi_rise  <= '0;
    end else begin
      swi_clean <= clean_nxt;
      swi_rise  <= clean_nxt & ~swi_clean;
    end
  end

  // Mode state register.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) state <= ST_STEP;
    else          state <= state_nxt;
  end

  // Next mode follows the clean mode switch; cpu_en comes from the divider in RUN, the step pulse otherwise.
  always_comb begin
    state_nxt = state;
    run_mode  = 1'b0;
    cpu_en    = step_en;
    case (state)
      ST_STEP: begin
        if (swi_clean[MODE_BIT]) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        run_mode = 1'b1;
        cpu_en   = (div == DIV_LAST);
        if (!swi_clean[MODE_BIT]) state_nxt = ST_STEP;
      end
      default: state_nxt = ST_STEP;
    endcase
  end

  // Divider runs only while staying in RUN; step pulses survive only while staying in STEP,
  // so a step rise coinciding with a mode change is dropped and RUN exits with cpu_en low.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      div     <= '0;
      step_en <= 1'b0;
    end else begin
      if ((state == ST_RUN) && (state_nxt == ST_RUN)) div <= (div == DIV_LAST) ? '0 : div + 1'b1;
      else                                            div <= '0;
      step_en <= (state == ST_STEP) && (state_nxt == ST_STEP) && swi_rise[STEP_BIT];
    end
  end

endmodule

// File: tb/tb_swi_step_ctrl.sv
// Purpose: directed bench for swi_step_ctrl with DB_CYCLES=4, RUN_DIV=4.
// Latency: inputs driven and outputs sampled 1ns after each rising clk_2 edge.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_swi_step_ctrl;

  logic       clk_2;
  logic       reset_n;
  logic [7:0] SWI;
  logic [7:0] swi_clean;
  logic [7:0] swi_rise;
  logic       cpu_en;
  logic       run_mode;

  int tests;
  int fails;

  swi_step_ctrl #(
    .NBITS(8), .DB_CYCLES(4), .RUN_DIV(4), .STEP_BIT(7), .MODE_BIT(6)
  ) dut (
    .clk_2(clk_2), .reset_n(reset_n), .SWI(SWI),
    .swi_clean(swi_clean), .swi_rise(swi_rise), .cpu_en(cpu_en), .run_mode(run_mode)
  );

  // 10 ns clock.
  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, bad, wide, rcnt, first, pulses, cpu_cnt;
    logic prev_rise, prev_cpu;
    tests   = 0;
    fails   = 0;
    reset_n = 1'b0;
    SWI     = 8'hFF;

    // 1. reset state, then reacquire with all switches high
    tick(); tick(); tick();
    chk("t1_rst_clean", swi_clean, 8'h00);
    chk("t1_rst_rise", swi_rise, 8'h00);
    chk("t1_rst_cpu_en", cpu_en, 0);
    chk("t1_rst_run_mode", run_mode, 0);
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("t1_clean_edge5", swi_clean, 8'h00);
      if (e == 6) begin
        chk("t1_clean_edge6", swi_clean, 8'hFF);
        chk("t1_rise_edge6", swi_rise, 8'hFF);
      end
      if (e == 7) begin
        chk("t1_rise_edge7", swi_rise, 8'h00);
        chk("t1_run_edge7", run_mode, 1);
        chk("t1_step_discarded", cpu_en, 0);
      end
    end
    SWI = 8'h00;
    for (int e = 0; e < 10; e++) tick();
    chk("t1_back_clean", swi_clean, 8'h00);
    chk("t1_back_run", run_mode, 0);
    chk("t1_back_cpu_en", cpu_en, 0);

    // 2. bouncing SWI[0], then held high
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      SWI[0] = (((c / 2) % 2) == 0);
      tick();
      if (swi_clean[0] !== 1'b0 || swi_rise[0] !== 1'b0) bad++;
    end
    chk("t2_bounce_quiet", bad, 0);
    SWI = 8'h01;
    rcnt = 0; first = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (swi_rise[0]) rcnt++;
      if (swi_clean[0] && first == 0) first = e;
    end
    chk("t2_latency", first, 6);
    chk("t2_rise_count", rcnt, 1);
    chk("t2_clean0", swi_clean[0], 1);

    // 3. 3-cycle glitch on SWI[2]
    bad = 0;
    SWI = 8'h05;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) SWI = 8'h01;
      tick();
      if (swi_clean[2] !== 1'b0 || swi_rise[2] !== 1'b0) bad++;
    end
    chk("t3_glitch_ignored", bad, 0);
    chk("t3_clean", swi_clean, 8'h01);

    // 4. STEP mode, three presses of SWI[7]
    chk("t4_step_mode", run_mode, 0);
    cpu_cnt = 0; rcnt = 0; bad = 0; wide = 0;
    prev_rise = 1'b0; prev_cpu = 1'b0;
    for (int c = 0; c < 64; c++) begin
      SWI = ((c % 20) < 10 && c < 60) ? 8'h81 : 8'h01;
      tick();
      if (cpu_en) cpu_cnt++;
      if (swi_rise[7]) rcnt++;
      if (cpu_en !== prev_rise) bad++;
      if (cpu_en && prev_cpu) wide++;
      prev_rise = swi_rise[7];
      prev_cpu  = cpu_en;
    end
    chk("t4_cpu_en_count", cpu_cnt, 3);
    chk("t4_rise7_count", rcnt, 3);
    chk("t4_cpu_en_lag", bad, 0);
    chk("t4_cpu_en_width", wide, 0);

    // 5. RUN mode
    SWI = 8'h41;
    n = 0;
    while (swi_clean[6] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_clean6_seen", swi_clean[6], 1);
    chk("t5_run_lags", run_mode, 0);
    tick();
    chk("t5_run_mode", run_mode, 1);
    pulses = 0; bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (cpu_en) pulses++;
      if (cpu_en !== ((c % 4) == 0)) bad++;
      if (c == 5)  SWI = 8'hC1;
      if (c == 20) SWI = 8'h41;
      if (c == 24) SWI = 8'hC1;
      if (c < 40) tick();
    end
    chk("t5_pulse_count", pulses, 10);
    chk("t5_pulse_pattern", bad, 0);
    SWI = 8'h81;
    n = 0;
    while (run_mode !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_run_off", run_mode, 0);
    chk("t5_first_step_cpu_en", cpu_en, 0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cpu_en) pulses++;
    end
    SWI = 8'h01;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cpu_en) pulses++;
    end
    chk("t5_no_pulses_after", pulses, 0);

    // 6. reset mid-RUN during a cpu_en cycle
    SWI = 8'h41;
    n = 0;
    while (run_mode !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (cpu_en !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("t6_pulse_seen", cpu_en, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_cpu_en", cpu_en, 0);
    chk("t6_async_run_mode", run_mode, 0);
    chk("t6_async_clean", swi_clean, 8'h00);
    chk("t6_async_rise", swi_rise, 8'h00);
    tick(); tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 1) chk("t6_step_after_release", run_mode, 0);
      if (e == 5) chk("t6_clean_edge5", swi_clean, 8'h00);
      if (e == 6) begin
        chk("t6_clean_edge6", swi_clean, 8'h41);
        chk("t6_rise_edge6", swi_rise, 8'h41);
        chk("t6_run_edge6", run_mode, 0);
      end
      if (e == 7) begin
        chk("t6_run_edge7", run_mode, 1);
        chk("t6_cpu_en_edge7", cpu_en, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
